lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
Single-port memory arbiter for the LC-3. It shares one synchronous memory between the CPU control path (fetch, LD/LDR/LDI, ST) and a debug/loader port used for program download and memory inspection. It latches the winning request, drives the memory port, waits the fixed read latency, and returns data with a one-cycle ack pulse. It sits between LC3Control/MAR-MDR and the memory macro.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
RD_LAT, 1, cycles from the mem_en cycle to mem_rdata valid; legal range 1..4
CPU_PRIO, 0, 0 = round-robin; 1 = CPU always wins a simultaneous request

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU request; held high with fields stable until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid in the cpu_ack cycle and held until the next CPU read completes
dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata  same as the cpu_* ports, for the debug port
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high in any non-IDLE state
owner  out  1  0 = CPU, 1 = debug; the last or current grantee

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all acks, mem_en, mem_we and busy = 0.
  - mem_addr, mem_wdata, cpu_rdata and dbg_rdata = 0.
  - owner=1, so the CPU wins the first tie.
  - Reset mid-transaction aborts it: no ack is issued and any pending write is not retried.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high: with CPU_PRIO=1 grant the CPU. Otherwise grant the requester that is not `owner`, so winners strictly alternate under contention.
  - At grant, latch we/addr/wdata, update owner, and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_en=1; mem_we=latched we; mem_addr/mem_wdata drive the latched values.
  - Write: go to RESP.
  - Read: go to WAIT.
- WAIT:
  - mem_en=0.
  - A down-counter is loaded with RD_LAT-1; the FSM stays RD_LAT-1 cycles before the capture cycle.
  - In the cycle RD_LAT after ISSUE, sample mem_rdata into the owner's rdata register and go to RESP.
  - For RD_LAT=1, WAIT lasts one cycle and that cycle is the capture cycle.
- RESP (1 cycle): pulse the owner's ack. Return to IDLE. Requests are not sampled in RESP.
- Latency, with req first high in IDLE at cycle 0:
  - Write: mem_en in cycle 1, ack in cycle 2.
  - Read: mem_en in cycle 1, ack in cycle RD_LAT+2.
  - Back-to-back requests from the same requester have a minimum spacing of one IDLE cycle.
- Requester rules:
  - Deassert req in the cycle after ack unless issuing a new transaction.
  - req held high in IDLE is treated as a new request.
  - A req dropped before ack is a protocol violation. The latched transaction still completes and acks.
- Non-owner rdata is never modified.
- Changes to addr/wdata/we after grant have no effect on the transaction.
- The two ack outputs are never high in the same cycle.
- mem_en is high for exactly one cycle per transaction.

Test Plan:
- CPU read, RD_LAT=1: mem holds x3000=x1234; cpu_req cycle 0 -> mem_en+addr x3000 in cycle 1, cpu_ack with cpu_rdata=x1234 in cycle 3, busy high in cycles 1-3.
- Debug write then CPU read: dbg writes xBEEF to x0040 (dbg_ack in cycle 2); then CPU reads x0040 -> cpu_rdata=xBEEF, and dbg_rdata is unchanged.
- Contention, CPU_PRIO=0: both reqs held high continuously for 4 transactions -> grant order CPU, DBG, CPU, DBG; acks never coincide.
- Contention, CPU_PRIO=1: both reqs held high for 3 transactions -> all CPU grants, no dbg_ack.
- RD_LAT=3: dbg read of x00FF=x00AA -> mem_en only in cycle 1, capture in cycle 4, dbg_ack with dbg_rdata=x00AA in cycle 5.
- Async reset asserted in WAIT of a CPU read -> outputs zero immediately, no cpu_ack. After release, a pending dbg_req is granted in the next IDLE cycle, with owner=1.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// lc3_mem_arbiter: shares one synchronous single-port memory between the
// LC-3 control path (cpu_*) and a debug/loader port (dbg_*).
//
// Handshake: a requester raises req with we/addr/wdata stable and holds it
// until its ack pulses for exactly one cycle. Fields are latched at grant, so
// later changes have no effect. A req still high when the arbiter is back in
// IDLE counts as a new transaction. A read's rdata is valid in the ack cycle
// and holds until that port's next read completes.
module lc3_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int RD_LAT   = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // WAIT spends RD_LAT-1 cycles counting down before its capture cycle.
  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              busy_q, busy_d;
  logic              grant_dbg;

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    // Debug wins when alone, or on a tie under round-robin when the CPU
    // was the last grantee.
    grant_dbg   = dbg_req && (!cpu_req || (CPU_PRIO == 0 && owner_q == 1'b0));
    unique case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d     = grant_dbg;
          mem_en_d    = 1'b1;
          mem_we_d    = grant_dbg ? dbg_we    : cpu_we;
          mem_addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
          mem_wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // mem_we_q still holds the latched direction during ISSUE.
        if (mem_we_q) begin
          state_d   = RESP;
          cpu_ack_d = !owner_q;
          dbg_ack_d = owner_q;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) begin
          if (owner_q) dbg_rdata_d = mem_rdata;
          else         cpu_rdata_d = mem_rdata;
          state_d   = RESP;
          cpu_ack_d = !owner_q;
          dbg_ack_d = owner_q;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b1;
      cnt_q       <= 2'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dbg_ack   = dbg_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign owner     = owner_q;
  assign fsm_state = state_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Bench for lc3_mem_arbiter. Three instances: [0] RD_LAT=1 round-robin,
// [1] RD_LAT=1 CPU priority, [2] RD_LAT=3 round-robin, each with its own
// memory model that drives xDEAD outside the single valid read-data cycle.
module tb_lc3_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req   [3];
  logic        cpu_we    [3];
  logic [15:0] cpu_addr  [3];
  logic [15:0] cpu_wdata [3];
  logic        cpu_ack   [3];
  logic [15:0] cpu_rdata [3];
  logic        dbg_req   [3];
  logic        dbg_we    [3];
  logic [15:0] dbg_addr  [3];
  logic [15:0] dbg_wdata [3];
  logic        dbg_ack   [3];
  logic [15:0] dbg_rdata [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [15:0] mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic        busy      [3];
  logic        owner     [3];
  logic [1:0]  fsm_state [3];

  int n_vec = 0;
  int n_bad = 0;

  // Scoreboard entry: {instance[1:0], port (0=cpu,1=dbg), rdata[15:0]}.
  logic [18:0] exp_q[$];

  // Per-cycle trace of one instance, bit/index k = cycle k of a transaction.
  logic [31:0] en_v, busy_v, cack_v, dack_v;
  logic [15:0] tr_addr  [32];
  logic [15:0] tr_wdata [32];
  logic        tr_we    [32];
  logic        tr_owner [32];
  int          n_acks;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs and memory models ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT  = (g == 2) ? 3 : 1;
    localparam int PRIO = (g == 1) ? 1 : 0;

    lc3_mem_arbiter #(
      .ADDR_W(16), .DATA_W(16), .RD_LAT(LAT), .CPU_PRIO(PRIO)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .dbg_req(dbg_req[g]), .dbg_we(dbg_we[g]), .dbg_addr(dbg_addr[g]),
      .dbg_wdata(dbg_wdata[g]), .dbg_ack(dbg_ack[g]), .dbg_rdata(dbg_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .owner(owner[g]), .fsm_state(fsm_state[g])
    );

    // Memory indexed by addr[7:0]; default word is xA500|index.
    logic [15:0] mem  [256];
    logic [15:0] pipe [4];
    logic        vld  [4];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
      mem[8'h00] = 16'h1234;  // x3000
      mem[8'hFF] = 16'h00AA;  // x00FF
      for (int i = 0; i < 4; i++) begin
        vld[i]  = 1'b0;
        pipe[i] = 16'h0;
      end
    end

    always @(posedge clk) begin
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
      vld[0]  <= mem_en[g] && !mem_we[g];
      pipe[0] <= mem[mem_addr[g][7:0]];
      for (int i = 1; i < 4; i++) begin
        vld[i]  <= vld[i-1];
        pipe[i] <= pipe[i-1];
      end
    end

    assign mem_rdata[g] = vld[LAT-1] ? pipe[LAT-1] : 16'hDEAD;
  end

  // ---------------- helpers ----------------
  function automatic logic [18:0] mk(input int d, input logic port, input logic [15:0] data);
    return {2'(d), port, data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    for (int d = 0; d < 3; d++) begin
      cpu_req[d] = 1'b0; cpu_we[d] = 1'b0; cpu_addr[d] = 16'h0; cpu_wdata[d] = 16'h0;
      dbg_req[d] = 1'b0; dbg_we[d] = 1'b0; dbg_addr[d] = 16'h0; dbg_wdata[d] = 16'h0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cpu_issue(input int d, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    cpu_req[d] = 1'b1; cpu_we[d] = we; cpu_addr[d] = addr; cpu_wdata[d] = wdata;
  endtask

  task automatic dbg_issue(input int d, input logic we, input logic [15:0] addr, input logic [15:0] wdata);
    dbg_req[d] = 1'b1; dbg_we[d] = we; dbg_addr[d] = addr; dbg_wdata[d] = wdata;
  endtask

  // Samples n cycles mid-cycle. max_acks==0: drop each req at its own ack;
  // otherwise hold both reqs and drop them together at the max_acks-th ack.
  task automatic trace(input int d, input int n, input int max_acks);
    en_v = '0; busy_v = '0; cack_v = '0; dack_v = '0; n_acks = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      en_v[k]     = mem_en[d];
      busy_v[k]   = busy[d];
      cack_v[k]   = cpu_ack[d];
      dack_v[k]   = dbg_ack[d];
      tr_addr[k]  = mem_addr[d];
      tr_wdata[k] = mem_wdata[d];
      tr_we[k]    = mem_we[d];
      tr_owner[k] = owner[d];
      if (cpu_ack[d] || dbg_ack[d]) begin
        n_acks++;
        if (max_acks == 0) begin
          if (cpu_ack[d]) cpu_req[d] = 1'b0;
          if (dbg_ack[d]) dbg_req[d] = 1'b0;
        end else if (n_acks == max_acks) begin
          cpu_req[d] = 1'b0;
          dbg_req[d] = 1'b0;
        end
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  task automatic check_ack(input int d, input logic port, input logic [15:0] data);
    logic [18:0] e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL ack_unexpected: dut%0d port=%0d rdata=%h with empty queue", d, port, data);
    end else begin
      e = exp_q.pop_front();
      if (e !== mk(d, port, data)) begin
        n_bad++;
        $display("FAIL ack_data: got dut%0d port=%0d rdata=%h expected dut%0d port=%0d rdata=%h",
                 d, port, data, e[18:17], e[16], e[15:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (cpu_ack[d] || dbg_ack[d]) begin
        n_vec++;
        if (cpu_ack[d] && dbg_ack[d]) begin
          n_bad++;
          $display("FAIL ack_overlap: dut%0d cpu_ack=1 dbg_ack=1 expected at most one", d);
        end
      end
      if (cpu_ack[d]) check_ack(d, 1'b0, cpu_rdata[d]);
      if (dbg_ack[d]) check_ack(d, 1'b1, dbg_rdata[d]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_en",    32'(mem_en[0]),    32'd0);
    chk("rst_mem_we",    32'(mem_we[0]),    32'd0);
    chk("rst_busy",      32'(busy[0]),      32'd0);
    chk("rst_owner",     32'(owner[0]),     32'd1);
    chk("rst_mem_addr",  32'(mem_addr[0]),  32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata[0]), 32'd0);
    chk("rst_acks",      32'({cpu_ack[0], dbg_ack[0]}), 32'd0);
    rst_n = 1'b1;

    // CPU read x3000 = x1234, RD_LAT=1
    sync();
    cpu_issue(0, 1'b0, 16'h3000, 16'h0);
    exp_q.push_back(mk(0, 1'b0, 16'h1234));
    trace(0, 5, 0);
    chk("t1_mem_en_cycles", {27'd0, en_v[4:0]},   32'b00010);
    chk("t1_mem_addr",      32'(tr_addr[1]),      32'h3000);
    chk("t1_mem_we",        32'(tr_we[1]),        32'd0);
    chk("t1_busy_cycles",   {27'd0, busy_v[4:0]}, 32'b01110);
    chk("t1_ack_cycles",    {27'd0, cack_v[4:0]}, 32'b01000);

    // Debug write xBEEF to x0040, then CPU reads it back
    sync();
    dbg_issue(0, 1'b1, 16'h0040, 16'hBEEF);
    exp_q.push_back(mk(0, 1'b1, 16'h0000));
    trace(0, 4, 0);
    chk("t2_mem_en_cycles", {28'd0, en_v[3:0]},   32'b0010);
    chk("t2_mem_we",        32'(tr_we[1]),        32'd1);
    chk("t2_mem_addr",      32'(tr_addr[1]),      32'h0040);
    chk("t2_mem_wdata",     32'(tr_wdata[1]),     32'hBEEF);
    chk("t2_dbg_ack_cycle", {28'd0, dack_v[3:0]}, 32'b0100);
    sync();
    cpu_issue(0, 1'b0, 16'h0040, 16'h0);
    exp_q.push_back(mk(0, 1'b0, 16'hBEEF));
    trace(0, 5, 0);
    chk("t2_cpu_ack_cycle", {27'd0, cack_v[4:0]}, 32'b01000);
    chk("t2_dbg_rdata_kept", 32'(dbg_rdata[0]),   32'h0000);

    // Round-robin contention: CPU, DBG, CPU, DBG
    do_reset();
    sync();
    cpu_issue(0, 1'b0, 16'h0011, 16'h0);
    dbg_issue(0, 1'b0, 16'h0022, 16'h0);
    exp_q.push_back(mk(0, 1'b0, 16'hA511));
    exp_q.push_back(mk(0, 1'b1, 16'hA522));
    exp_q.push_back(mk(0, 1'b0, 16'hA511));
    exp_q.push_back(mk(0, 1'b1, 16'hA522));
    trace(0, 20, 4);
    chk("t3_ack_count",   32'(n_acks),          32'd4);
    chk("t3_cpu_acks",    {16'd0, cack_v[15:0]}, 32'h0808);
    chk("t3_dbg_acks",    {16'd0, dack_v[15:0]}, 32'h8080);
    chk("t3_no_overlap",  cack_v & dack_v,       32'd0);

    // CPU-priority contention: three CPU grants, debug starved
    sync();
    cpu_issue(1, 1'b0, 16'h0033, 16'h0);
    dbg_issue(1, 1'b0, 16'h0044, 16'h0);
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 1'b0, 16'hA533));
    trace(1, 16, 3);
    chk("t4_cpu_acks", {16'd0, cack_v[15:0]}, 32'h0888);
    chk("t4_no_dbg",   dack_v,                32'd0);

    // RD_LAT=3 debug read x00FF = x00AA
    sync();
    dbg_issue(2, 1'b0, 16'h00FF, 16'h0);
    exp_q.push_back(mk(2, 1'b1, 16'h00AA));
    trace(2, 7, 0);
    chk("t5_mem_en_cycles", {25'd0, en_v[6:0]},   32'b0000010);
    chk("t5_mem_addr",      32'(tr_addr[1]),      32'h00FF);
    chk("t5_busy_cycles",   {25'd0, busy_v[6:0]}, 32'b0111110);
    chk("t5_ack_cycle",     {25'd0, dack_v[6:0]}, 32'b0100000);

    // Async reset during WAIT of a CPU read, pending debug read after
    sync();
    cpu_issue(0, 1'b0, 16'h3000, 16'h0);
    repeat (3) @(negedge clk);
    chk("t6_in_wait", 32'(fsm_state[0]), 32'd2);
    rst_n = 1'b0;
    cpu_req[0] = 1'b0;
    dbg_issue(0, 1'b0, 16'h0044, 16'h0);
    #1;
    chk("t6_rst_busy",      32'(busy[0]),      32'd0);
    chk("t6_rst_mem_addr",  32'(mem_addr[0]),  32'd0);
    chk("t6_rst_cpu_rdata", 32'(cpu_rdata[0]), 32'd0);
    chk("t6_rst_owner",     32'(owner[0]),     32'd1);
    chk("t6_rst_state",     32'(fsm_state[0]), 32'd0);
    chk("t6_rst_cpu_ack",   32'(cpu_ack[0]),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(0, 1'b1, 16'hA544));
    trace(0, 5, 0);
    chk("t6_mem_en_cycles", {27'd0, en_v[4:0]},   32'b00010);
    chk("t6_mem_addr",      32'(tr_addr[1]),      32'h0044);
    chk("t6_owner",         32'(tr_owner[1]),     32'd1);
    chk("t6_dbg_ack_cycle", {27'd0, dack_v[4:0]}, 32'b01000);
    chk("t6_no_cpu_ack",    cack_v,               32'd0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
